// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler: round-robin sharing of one serial sequence detector among requesters
module seq_det_scheduler #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int DET_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     data,
    output logic [N_REQ-1:0]           gnt,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(N_REQ)-1:0]   done_id,
    output logic [CNT_W-1:0]           hit_cnt,
    output logic                       det_rst_n,
    output logic                       det_in,
    input  logic                       det_out,
    output logic [2:0]                 state
);
    localparam int IW = $clog2(N_REQ);
    localparam int PW = $clog2(WIDTH + DET_LAT + 1);
    typedef enum logic [2:0] {IDLE = 3'd0, CLR = 3'd1, SHIFT = 3'd2, DRAIN = 3'd3, DONE = 3'd4} st_t;
    st_t              st;
    logic [IW-1:0]    ptr, pick, cur, j;
    logic             found;
    logic [WIDTH-1:0] word;
    logic [PW-1:0]    ph;
    logic [CNT_W-1:0] hits, hits_n;
    assign state  = st;
    assign hits_n = hits + CNT_W'(ph >= PW'(DET_LAT) && det_out);
    // first requesting index at or after the round-robin pointer
    always_comb begin
        found = 1'b0;
        pick  = '0;
        j     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = IW'((int'(ptr) + k) % N_REQ);
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = j;
            end
        end
    end
    // job sequencer: grant, clear detector, shift word MSB-first, drain, report
    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_id   <= '0;
            hit_cnt   <= '0;
            det_rst_n <= 1'b1;
            det_in    <= 1'b0;
            ptr       <= '0;
            cur       <= '0;
            word      <= '0;
            ph        <= '0;
            hits      <= '0;
        end else begin
            done <= 1'b0;
            case (st)
                IDLE: if (found) begin
                    st        <= CLR;
                    gnt       <= N_REQ'(1) << pick;
                    busy      <= 1'b1;
                    cur       <= pick;
                    word      <= data[pick*WIDTH +: WIDTH];
                    ptr       <= (pick == IW'(N_REQ - 1)) ? '0 : pick + 1'b1;
                    det_rst_n <= 1'b0;
                    det_in    <= 1'b0;
                end
                CLR: begin
                    st        <= SHIFT;
                    det_rst_n <= 1'b1;
                    det_in    <= word[WIDTH-1];
                    word      <= word << 1;
                    ph        <= '0;
                    hits      <= '0;
                end
                SHIFT, DRAIN: begin
                    det_in <= word[WIDTH-1];
                    word   <= word << 1;
                    ph     <= ph + 1'b1;
                    hits   <= hits_n;
                    if (st == SHIFT && ph == PW'(WIDTH - 1))
                        st <= DRAIN;
                    if (st == DRAIN && ph == PW'(WIDTH + DET_LAT - 1)) begin
                        st      <= DONE;
                        done    <= 1'b1;
                        hit_cnt <= hits_n;
                        done_id <= cur;
                    end
                end
                DONE: begin
                    st   <= IDLE;
                    gnt  <= '0;
                    busy <= 1'b0;
                end
                default: begin
                    st        <= IDLE;
                    gnt       <= '0;
                    busy      <= 1'b0;
                    det_rst_n <= 1'b1;
                    det_in    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_det_scheduler.sv
// tb_seq_det_scheduler: randomized self-checking bench with a "100" detector model
module tb_seq_det_scheduler;
    logic        clk = 1'b0, reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] data = '0;
    logic [3:0]  gnt;
    logic        busy, done, det_rst_n, det_in, det_out;
    logic [1:0]  done_id;
    logic [3:0]  hit_cnt;
    logic [2:0]  state;
    logic [1:0]  ds = '0;
    bit          force_one = 1'b0;
    int          n_cmp = 0, n_err = 0, ptr_m = 0, g;

    always #5 clk = ~clk;

    seq_det_scheduler dut (
        .clk(clk), .reset(reset), .req(req), .data(data), .gnt(gnt), .busy(busy),
        .done(done), .done_id(done_id), .hit_cnt(hit_cnt), .det_rst_n(det_rst_n),
        .det_in(det_in), .det_out(det_out), .state(state)
    );

    // external Moore detector: overlapping "100", one cycle of latency
    always @(posedge clk)
        ds <= !det_rst_n ? 2'd0 : det_in ? 2'd1 : (ds == 2'd1) ? 2'd2 : (ds == 2'd2) ? 2'd3 : 2'd0;
    assign det_out = force_one | (ds == 2'd3);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int hits_of(input logic [7:0] w);
        int h = 0;
        for (int i = 0; i < 6; i++)
            if (w[i+2] && !w[i+1] && !w[i]) h++;
        return h;
    endfunction

    function automatic int pick_m(input logic [3:0] r);
        for (int k = 0; k < 4; k++)
            if (r[(ptr_m + k) % 4]) return (ptr_m + k) % 4;
        return 0;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset", {state, gnt, busy, done, det_rst_n, det_in}, {3'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0});
        reset = 1'b0;
        ptr_m = 0;
    endtask

    // mode 1: overwrite granted word after grant; mode 2: drop req0/raise req3 mid-shift
    // rel 1: release own request at done; rel 2: release all
    task automatic run_job(input int mode, input int rel, output int gap);
        int idx, lat, exp_h;
        logic [7:0] w;
        idx = pick_m(req);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (gnt == 0 && gap < 50);
        chk("gnt", gnt, 32'(1) << idx);
        ptr_m = (idx + 1) % 4;
        w = data[idx*8 +: 8];
        exp_h = force_one ? 8 : hits_of(w);
        chk("clr", {state, det_rst_n, busy}, {3'd1, 1'b0, 1'b1});
        if (mode == 1) data[idx*8 +: 8] = 8'hFF;
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            lat++;
            chk("det_in", det_in, w[7-k]);
            if (mode == 2 && k == 3) begin
                req[0] = 1'b0;
                req[3] = 1'b1;
            end
        end
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 10);
        chk("done_id", done_id, idx);
        chk("hit_cnt", hit_cnt, exp_h);
        if (rel == 1) req[idx] = 1'b0;
        else if (rel == 2) req = '0;
        @(negedge clk);
        chk("idle", {done, gnt, busy, hit_cnt}, {1'b0, 4'd0, 1'b0, 4'(exp_h)});
    endtask

    initial begin
        do_reset();
        data[7:0] = 8'b1001_0010;
        req = 4'b0001;
        run_job(0, 1, g);
        do_reset();
        data = '0;
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            run_job(0, (n == 4) ? 2 : 0, g);
            if (n > 0) chk("gap", g, 1);
        end
        data[23:16] = 8'b1001_0000;
        req = 4'b0100;
        run_job(1, 1, g);
        req = 4'b0010;
        data[15:8] = 8'hA5;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (gnt == 0 && g < 50);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        req = '0;
        @(negedge clk);
        chk("mid_reset", {state, gnt, det_rst_n, done, busy}, {3'd0, 4'd0, 1'b1, 1'b0, 1'b0});
        reset = 1'b0;
        ptr_m = 0;
        @(negedge clk);
        chk("no_done", done, 0);
        req = 4'b1010;
        run_job(0, 1, g);
        run_job(0, 1, g);
        force_one = 1'b1;
        data[7:0] = $urandom;
        req = 4'b0001;
        run_job(0, 1, g);
        force_one = 1'b0;
        data[7:0] = 8'b0100_1000;
        req = 4'b0001;
        run_job(2, 0, g);
        run_job(0, 1, g);
        for (int n = 0; n < 12; n++) begin
            if (req == 0) begin
                req = 4'($urandom_range(1, 15));
                data = $urandom;
            end
            run_job(0, 1, g);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
